// File: rtl/iterative_divider_seq.sv
// Multi-cycle signed/unsigned divider: non-restoring iteration on magnitudes,
// BITS_PER_CYCLE quotient bits per ITER cycle, sign fix-up in a final FIX cycle.
module iterative_divider_seq #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             in_clk,
  input  logic             in_reset,
  input  logic             in_start,
  input  logic             in_signed,
  input  logic [WIDTH-1:0] in_dividend,
  input  logic [WIDTH-1:0] in_divisor,
  output logic             out_busy,
  output logic             out_done,
  output logic [WIDTH-1:0] out_quotient,
  output logic [WIDTH-1:0] out_remainder,
  output logic             out_div_by_zero,
  output logic             out_overflow,
  output logic [2:0]       out_dbg_state
);

  localparam int N     = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(N + 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PREP = 3'd1;
  localparam logic [2:0] S_ITER = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             sgn_q, sgn_d;
  logic [WIDTH-1:0] qd_q, qd_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             ovf_pend_q, ovf_pend_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH:0]   r_t;
  logic [WIDTH-1:0] q_t;
  logic [WIDTH-1:0] r_fix;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;

  always_comb begin
    state_d    = state_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    sgn_d      = sgn_q;
    qd_d       = qd_q;
    r_d        = r_q;
    cnt_d      = cnt_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    ovf_pend_d = ovf_pend_q;
    quo_d      = quo_q;
    rem_d      = rem_q;
    dbz_d      = dbz_q;
    ovf_d      = ovf_q;
    r_t        = r_q;
    q_t        = qd_q;
    r_fix      = r_q[WIDTH-1:0];
    mag_a      = (sgn_q && dvd_q[WIDTH-1]) ? -dvd_q : dvd_q;
    mag_b      = (sgn_q && dvs_q[WIDTH-1]) ? -dvs_q : dvs_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (in_start) begin
          dvd_d   = in_dividend;
          dvs_d   = in_divisor;
          sgn_d   = in_signed;
          state_d = S_PREP;
        end
      end
      S_PREP: begin
        neg_quo_d  = sgn_q & (dvd_q[WIDTH-1] ^ dvs_q[WIDTH-1]);
        neg_rem_d  = sgn_q & dvd_q[WIDTH-1];
        ovf_pend_d = sgn_q && (dvd_q == {1'b1, {(WIDTH-1){1'b0}}}) && (dvs_q == '1);
        qd_d       = mag_a;
        dvs_d      = mag_b;
        r_d        = '0;
        cnt_d      = CNT_W'(N);
        if (dvs_q == '0) begin
          // dvd_q still holds the raw dividend, reported unmodified
          quo_d   = '1;
          rem_d   = dvd_q;
          dbz_d   = 1'b1;
          ovf_d   = 1'b0;
          state_d = S_DONE;
        end else begin
          state_d = S_ITER;
        end
      end
      S_ITER: begin
        // W+1-bit arithmetic may wrap in the shift, but each step lands in [-d, d)
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
          if (!r_t[WIDTH]) r_t = {r_t[WIDTH-1:0], q_t[WIDTH-1]} - {1'b0, dvs_q};
          else             r_t = {r_t[WIDTH-1:0], q_t[WIDTH-1]} + {1'b0, dvs_q};
          q_t = {q_t[WIDTH-2:0], ~r_t[WIDTH]};
        end
        r_d   = r_t;
        qd_d  = q_t;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = S_FIX;
      end
      S_FIX: begin
        r_fix   = r_q[WIDTH] ? (r_q[WIDTH-1:0] + dvs_q) : r_q[WIDTH-1:0];
        quo_d   = neg_quo_q ? -qd_q : qd_q;
        rem_d   = neg_rem_q ? -r_fix : r_fix;
        dbz_d   = 1'b0;
        ovf_d   = ovf_pend_q;
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge in_clk) begin
    if (in_reset) begin
      state_q    <= S_IDLE;
      dvd_q      <= '0;
      dvs_q      <= '0;
      sgn_q      <= 1'b0;
      qd_q       <= '0;
      r_q        <= '0;
      cnt_q      <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      ovf_pend_q <= 1'b0;
      quo_q      <= '0;
      rem_q      <= '0;
      dbz_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      sgn_q      <= sgn_d;
      qd_q       <= qd_d;
      r_q        <= r_d;
      cnt_q      <= cnt_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      ovf_pend_q <= ovf_pend_d;
      quo_q      <= quo_d;
      rem_q      <= rem_d;
      dbz_q      <= dbz_d;
      ovf_q      <= ovf_d;
    end
  end

  assign out_busy        = (state_q == S_PREP) || (state_q == S_ITER) || (state_q == S_FIX);
  assign out_done        = (state_q == S_DONE);
  assign out_quotient    = quo_q;
  assign out_remainder   = rem_q;
  assign out_div_by_zero = dbz_q;
  assign out_overflow    = ovf_q;
  assign out_dbg_state   = state_q;

endmodule

// File: tb/tb_iterative_divider_seq.sv
// Bench for iterative_divider_seq: three 32-bit instances (1, 2 and 4 bits per cycle),
// directed vectors on the 1-bit unit, model-checked random vectors on the others.
module tb_iterative_divider_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  start, sgn, busy, done, dbz, ovf;
  logic [31:0] dvd [3];
  logic [31:0] dvs [3];
  logic [31:0] quo [3];
  logic [31:0] rem [3];
  logic [2:0]  st  [3];
  logic [31:0] last_q [3];

  int checks   = 0;
  int failures = 0;
  int bpc_of [3] = '{1, 2, 4};

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    iterative_divider_seq #(.WIDTH(32), .BITS_PER_CYCLE((g == 0) ? 1 : (g == 1) ? 2 : 4)) u_dut (
      .in_clk          (clk),
      .in_reset        (reset),
      .in_start        (start[g]),
      .in_signed       (sgn[g]),
      .in_dividend     (dvd[g]),
      .in_divisor      (dvs[g]),
      .out_busy        (busy[g]),
      .out_done        (done[g]),
      .out_quotient    (quo[g]),
      .out_remainder   (rem[g]),
      .out_div_by_zero (dbz[g]),
      .out_overflow    (ovf[g]),
      .out_dbg_state   (st[g])
    );
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int u, input logic s, input logic [31:0] a, input logic [31:0] b);
    start[u] = 1'b1;
    sgn[u]   = s;
    dvd[u]   = a;
    dvs[u]   = b;
  endtask

  // Called at a negedge with start already driven; the next posedge is the accept edge.
  task automatic wait_check(input int u, input logic [31:0] eq, input logic [31:0] er,
                            input logic edbz, input logic eovf, input int elat,
                            input int poke, input bit hold, input string tag);
    int c;
    @(posedge clk);
    c = 0;
    @(negedge clk);
    while (!done[u] && c < 200) begin
      start[u] = (c == poke);
      dvd[u]   = $urandom;
      dvs[u]   = $urandom;
      if (c == 0) check({tag, " busy"}, busy[u], 1);
      if (c == 2) check({tag, " held_q"}, quo[u], last_q[u]);
      @(posedge clk);
      c++;
      @(negedge clk);
    end
    start[u] = 1'b0;
    // done seen after edge E0+c means it is sampled high at edge E0+c+1
    check({tag, " latency"}, c + 1, elat);
    check({tag, " quotient"}, quo[u], eq);
    check({tag, " remainder"}, rem[u], er);
    check({tag, " div_by_zero"}, dbz[u], edbz);
    check({tag, " overflow"}, ovf[u], eovf);
    check({tag, " busy_in_done"}, busy[u], 0);
    last_q[u] = eq;
    if (!hold) begin
      @(posedge clk);
      @(negedge clk);
      check({tag, " done_pulse"}, done[u], 0);
    end
  endtask

  function automatic void model(input logic s, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r,
                                output logic mdbz, output logic movf);
    mdbz = 1'b0;
    movf = 1'b0;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a; mdbz = 1'b1;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = a; r = 32'd0; movf = 1'b1;
    end else if (s) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  initial begin
    logic [31:0] mq, mr, ra, rb;
    logic        md, mo, rs;
    int          n_done;
    reset = 1'b1;
    start = '0;
    sgn   = '0;
    for (int i = 0; i < 3; i++) begin
      dvd[i] = '0; dvs[i] = '0; last_q[i] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("reset busy", busy[0], 0);
    check("reset done", done[0], 0);
    check("reset quotient", quo[0], 0);
    check("reset remainder", rem[0], 0);
    check("reset flags", {dbz[0], ovf[0]}, 0);
    check("reset state", st[0], 0);

    drive(0, 0, 32'd12, 32'd7);
    wait_check(0, 32'd1, 32'd5, 0, 0, 35, -1, 0, "u12div7");
    drive(0, 1, 32'hFFFF_FFF9, 32'd2);
    wait_check(0, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0, 0, 35, -1, 0, "sm7div2");
    drive(0, 1, 32'd7, 32'hFFFF_FFFE);
    wait_check(0, 32'hFFFF_FFFD, 32'd1, 0, 0, 35, -1, 0, "s7divm2");
    drive(0, 0, 32'hFFFF_FFFF, 32'h10);
    wait_check(0, 32'h0FFF_FFFF, 32'hF, 0, 0, 35, -1, 0, "umaxdiv16");
    drive(0, 0, 32'h1234, 32'd0);
    wait_check(0, 32'hFFFF_FFFF, 32'h1234, 1, 0, 2, -1, 0, "divzero");
    drive(0, 1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_check(0, 32'h8000_0000, 32'd0, 0, 1, 35, -1, 0, "mindivm1");
    drive(0, 0, 32'd100, 32'd10);
    wait_check(0, 32'd10, 32'd0, 0, 0, 35, -1, 0, "u100div10");
    drive(0, 0, 32'd100, 32'd7);
    wait_check(0, 32'd14, 32'd2, 0, 0, 35, 6, 0, "start_while_busy");
    drive(0, 0, 32'd50, 32'd7);
    wait_check(0, 32'd7, 32'd1, 0, 0, 35, -1, 1, "b2b_first");
    drive(0, 0, 32'd99, 32'd10);
    wait_check(0, 32'd9, 32'd9, 0, 0, 35, -1, 0, "b2b_second");

    // Reset in the middle of ITER, with a competing start in the same cycle
    drive(0, 0, 32'd1000, 32'd3);
    @(posedge clk);
    @(negedge clk);
    start[0] = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset    = 1'b1;
    start[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset    = 1'b0;
    start[0] = 1'b0;
    check("midreset busy", busy[0], 0);
    check("midreset done", done[0], 0);
    check("midreset quotient", quo[0], 0);
    check("midreset remainder", rem[0], 0);
    check("midreset state", st[0], 0);
    n_done = 0;
    repeat (50) begin
      @(negedge clk);
      if (done[0]) n_done++;
    end
    check("midreset no_done", n_done, 0);
    for (int i = 0; i < 3; i++) last_q[i] = '0;

    for (int u = 1; u < 3; u++) begin
      for (int k = 0; k < 8; k++) begin
        if (k == 0) begin
          rs = 1; ra = 32'h8000_0000; rb = 32'hFFFF_FFFF;
        end else if (k == 1) begin
          rs = 1; ra = 32'hFFFF_FFF9; rb = 32'd2;
        end else begin
          rs = 1'($urandom_range(0, 1));
          ra = $urandom;
          rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
        end
        model(rs, ra, rb, mq, mr, md, mo);
        drive(u, rs, ra, rb);
        wait_check(u, mq, mr, md, mo, md ? 2 : (32 / bpc_of[u] + 3), -1, 0,
                   $sformatf("bpc%0d_v%0d", bpc_of[u], k));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/iterative_divider_seq.md
ITERATIVE_DIVIDER_SEQ -- requirements
Module: iterative_divider_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; legal values 4..64, even.
REQ-002 SHALL have parameter BITS_PER_CYCLE, default 1, quotient bits retired per iteration; legal values 1, 2, 4; WIDTH mod BITS_PER_CYCLE = 0.
REQ-003 SHALL have port in_clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port in_reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_start  input  1  request to begin a division.
REQ-006 SHALL have port in_signed  input  1  1 = two's-complement operands, 0 = unsigned.
REQ-007 SHALL have port in_dividend  input  WIDTH  dividend.
REQ-008 SHALL have port in_divisor  input  WIDTH  divisor.
REQ-009 SHALL have port out_busy  output  1  high while a division is in progress.
REQ-010 SHALL have port out_done  output  1  one-cycle pulse, result valid.
REQ-011 SHALL have port out_quotient  output  WIDTH  quotient.
REQ-012 SHALL have port out_remainder  output  WIDTH  remainder.
REQ-013 SHALL have port out_div_by_zero  output  1  last division had divisor 0.
REQ-014 SHALL have port out_overflow  output  1  last division was signed MIN / -1.

Function
REQ-015 SHALL implement FSM states IDLE, PREP, ITER, FIX, DONE; N = WIDTH/BITS_PER_CYCLE.
REQ-016 SHALL in IDLE accept in_start=1 at a rising edge (accept edge E0), registering in_dividend, in_divisor, in_signed, and move to PREP.
REQ-017 SHALL ignore in_start in every state other than IDLE and DONE; operand inputs are don't-care after E0.
REQ-018 SHALL in PREP take magnitudes of operands when signed, record result signs (quotient sign = XOR of operand signs, remainder sign = dividend sign), clear partial remainder, load iteration counter with N.
REQ-019 SHALL in PREP, if divisor = 0, go directly to DONE; otherwise go to ITER.
REQ-020 SHALL in ITER perform non-restoring division on unsigned magnitudes, BITS_PER_CYCLE quotient bits per cycle, partial remainder WIDTH+1 bits, decrementing the counter; exit to FIX after exactly N ITER cycles.
REQ-021 SHALL in FIX add divisor back if partial remainder negative, then apply recorded signs (negate quotient/remainder when required), and go to DONE.
REQ-022 SHALL round signed quotient toward zero; remainder takes dividend's sign; dividend = quotient*divisor + remainder (mod 2^WIDTH) for all non-zero divisors.
REQ-023 SHALL assert out_done for exactly the one cycle in DONE: normal path at edge E0+N+3 (32/1: edge 35), divide-by-zero path at edge E0+2.
REQ-024 SHALL in DONE return to IDLE next edge, or, if in_start=1, accept a new division directly (DONE acts as accept edge, next state PREP).
REQ-025 SHALL assert out_busy in PREP, ITER, FIX; deassert in IDLE and DONE.
REQ-026 SHALL on divide-by-zero output quotient = all ones, remainder = registered dividend (unmodified), out_div_by_zero = 1, out_overflow = 0.
REQ-027 SHALL on signed MIN / -1 output quotient = MIN (wrapped), remainder = 0, out_overflow = 1.
REQ-028 SHALL hold out_quotient, out_remainder, out_div_by_zero, out_overflow stable from DONE until the next DONE; they are not updated during busy states.

Reset
REQ-029 SHALL on in_reset=1 at a rising edge enter IDLE, clear out_busy, out_done, out_quotient, out_remainder, out_div_by_zero, out_overflow to 0, regardless of state.
REQ-030 SHALL give in_reset priority over in_start in the same cycle; a division interrupted by reset produces no out_done.

Verification
REQ-031 SHALL cover unsigned 12 / 7, WIDTH=32, BPC=1 -> out_done at E0+35, quotient 1, remainder 5, flags 0.
REQ-032 SHALL cover signed -7 / 2 and 7 / -2 -> quotient -3/-3, remainder -1/1; unsigned 0xFFFFFFFF / 0x10 -> 0x0FFFFFFF, 0xF.
REQ-033 SHALL cover divisor 0 with dividend 0x1234 -> out_done at E0+2, quotient 0xFFFFFFFF, remainder 0x1234, out_div_by_zero 1.
REQ-034 SHALL cover signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0, out_overflow 1.
REQ-035 SHALL cover in_start pulsed while busy (ignored, result unchanged) and back-to-back start in DONE (second out_done exactly N+3 edges later).
REQ-036 SHALL cover in_reset asserted mid-ITER -> IDLE next edge, all outputs 0, no out_done; plus BPC=2 and BPC=4 random compare against reference model (latency N+3).
